// File: rtl/vfu_pkg.sv
// vfu_pkg: shared widths, MAC latency default and sequencer state encoding for the MAC VFU
package vfu_pkg;
  localparam int DATA_W_DEFAULT = 32;
  localparam int LEN_W_DEFAULT = 8;
  localparam int MAC_LAT_DEFAULT = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
endpackage

// File: rtl/vfu_mac_sequencer.sv
// vfu_mac_sequencer: issues vector FMA element triples to the MAC one at a time and streams back results
module vfu_mac_sequencer
  import vfu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT,
  parameter int MAC_LAT = MAC_LAT_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                elem_valid,
  output logic                elem_ready,
  input  logic [DATA_W-1:0]   elem_a,
  input  logic [DATA_W-1:0]   elem_b,
  input  logic [DATA_W-1:0]   elem_c,
  output logic                mac_en,
  output logic [DATA_W-1:0]   mac_m1,
  output logic [DATA_W-1:0]   mac_m2,
  output logic [DATA_W-1:0]   mac_addend,
  input  logic [2*DATA_W-1:0] mac_result,
  input  logic                mac_rdy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*DATA_W-1:0] res_data,
  output logic                res_last,
  output logic                done,
  output logic                busy,
  output logic                err
);
  localparam int LAT_W = $clog2(MAC_LAT + 1);
  state_t state;
  logic [LEN_W-1:0] rem;
  logic [LAT_W-1:0] cnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cmd_ready <= 1'b1;
      elem_ready <= 1'b0;
      mac_en <= 1'b0;
      mac_m1 <= '0;
      mac_m2 <= '0;
      mac_addend <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_last <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      rem <= '0;
      cnt <= '0;
    end else begin
      mac_en <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_len == '0) done <= 1'b1;
          else begin
            rem <= cmd_len;
            cmd_ready <= 1'b0;
            elem_ready <= 1'b1;
            busy <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: if (elem_valid) begin
          mac_m1 <= elem_a;
          mac_m2 <= elem_b;
          mac_addend <= elem_c;
          mac_en <= 1'b1;
          elem_ready <= 1'b0;
          cnt <= LAT_W'(MAC_LAT);
          state <= WAIT;
        end
        // cnt reaches zero in the cycle the MAC result becomes valid
        WAIT: if (cnt == '0) begin
          res_data <= mac_result;
          res_last <= (rem == LEN_W'(1));
          res_valid <= 1'b1;
          if (!mac_rdy) err <= 1'b1;
          state <= OUT;
        end else cnt <= cnt - LAT_W'(1);
        OUT: if (res_ready) begin
          res_valid <= 1'b0;
          rem <= rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            done <= 1'b1;
            busy <= 1'b0;
            cmd_ready <= 1'b1;
            state <= IDLE;
          end else begin
            elem_ready <= 1'b1;
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vfu_mac_sequencer.sv
// tb_vfu_mac_sequencer: directed bench driving the sequencer against a latency-3 MAC model with skip-on-identical operands
module tb_vfu_mac_sequencer;
  logic CLK = 1'b0, RST = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [7:0] cmd_len = '0;
  logic elem_valid = 1'b0, elem_ready;
  logic [31:0] elem_a = '0, elem_b = '0, elem_c = '0;
  logic mac_en;
  logic [31:0] mac_m1, mac_m2, mac_addend;
  logic [63:0] mac_result = '0;
  logic mac_rdy = 1'b1;
  logic res_valid, res_ready = 1'b0;
  logic [63:0] res_data;
  logic res_last, done, busy, err;
  int checks = 0, errors = 0, en_cnt = 0;
  logic [63:0] p1 = '0, p2 = '0;
  logic [95:0] last_ops = '0;
  logic fired = 1'b0;

  always #5 CLK = ~CLK;

  vfu_mac_sequencer dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .elem_valid(elem_valid), .elem_ready(elem_ready),
    .elem_a(elem_a), .elem_b(elem_b), .elem_c(elem_c),
    .mac_en(mac_en), .mac_m1(mac_m1), .mac_m2(mac_m2), .mac_addend(mac_addend),
    .mac_result(mac_result), .mac_rdy(mac_rdy),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .done(done), .busy(busy), .err(err)
  );

  // MAC model: result visible 3 cycles after the mac_en cycle; identical operands do not re-fire
  always @(posedge CLK) begin
    if (mac_en) en_cnt <= en_cnt + 1;
    if (mac_en && (!fired || last_ops != {mac_m1, mac_m2, mac_addend})) begin
      p1 <= {32'b0, mac_m1} * {32'b0, mac_m2} + {32'b0, mac_addend};
      last_ops <= {mac_m1, mac_m2, mac_addend};
      fired <= 1'b1;
    end
    p2 <= p1;
    mac_result <= p2;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_len = len;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (n == 100) chk("cmd_tmo", 0, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_elem(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int n = 0;
    elem_valid = 1'b1;
    elem_a = a;
    elem_b = b;
    elem_c = c;
    while (!elem_ready && n < 100) begin tick(); n++; end
    if (n == 100) chk("elem_tmo", 0, 1);
    tick();
    elem_valid = 1'b0;
  endtask

  task automatic get_res(input string tag, input logic [63:0] d, input logic l);
    int n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_data"}, res_data, d);
    chk({tag, "_last"}, res_last, l);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int e0;
    logic stable;
    repeat (2) tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_elem_ready", elem_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_data", res_data, 0);
    RST = 1'b0;
    tick();

    // single element, zero-stall consumer, exact latency
    res_ready = 1'b1;
    e0 = en_cnt;
    send_cmd(1);
    chk("t1_busy", busy, 1);
    send_elem(3, 5, 7);
    chk("t1_mac_en", mac_en, 1);
    chk("t1_ops", {mac_m1, mac_m2}, {32'd3, 32'd5});
    repeat (3) tick();
    chk("t1_early", res_valid, 0);
    tick();
    chk("t1_valid", res_valid, 1);
    chk("t1_data", res_data, 64'd22);
    chk("t1_last", res_last, 1);
    tick();
    chk("t1_done", done, 1);
    chk("t1_busy_fall", busy, 0);
    chk("t1_cmd_ready", cmd_ready, 1);
    tick();
    chk("t1_done_once", done, 0);
    chk("t1_en_cnt", en_cnt - e0, 1);
    res_ready = 1'b0;

    // length 4 including a full-width product
    e0 = en_cnt;
    send_cmd(4);
    send_elem(32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    get_res("t2_r0", 64'hFFFFFFFE00000002, 0);
    send_elem(10, 20, 30);
    get_res("t2_r1", 64'd230, 0);
    send_elem(32'h80000000, 2, 5);
    get_res("t2_r2", 64'h0000000100000005, 0);
    send_elem(0, 7, 9);
    get_res("t2_r3", 64'd9, 1);
    tick();
    chk("t2_en_cnt", en_cnt - e0, 4);
    chk("t2_busy", busy, 0);

    // identical consecutive triples
    send_cmd(2);
    send_elem(2, 2, 2);
    get_res("t3_r0", 64'd6, 0);
    send_elem(2, 2, 2);
    get_res("t3_r1", 64'd6, 1);
    chk("t3_err", err, 0);

    // back-pressure for 10 cycles
    send_cmd(1);
    send_elem(4, 5, 6);
    while (!res_valid) tick();
    e0 = en_cnt;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (!res_valid || res_data !== 64'd26 || res_last !== 1'b1 || elem_ready) stable = 1'b0;
    end
    chk("t4_stable", stable, 1);
    chk("t4_no_en", en_cnt - e0, 0);
    get_res("t4_r", 64'd26, 1);
    chk("t4_idle", cmd_ready, 1);

    // zero-length command
    e0 = en_cnt;
    send_cmd(0);
    chk("t5_done", done, 1);
    chk("t5_cmd_ready", cmd_ready, 1);
    chk("t5_elem_ready", elem_ready, 0);
    tick();
    chk("t5_done_once", done, 0);
    chk("t5_no_en", en_cnt - e0, 0);

    // mac_rdy low at capture sets sticky err
    mac_rdy = 1'b0;
    send_cmd(1);
    send_elem(9, 9, 0);
    get_res("t6_r", 64'd81, 1);
    mac_rdy = 1'b1;
    tick();
    chk("t6_err", err, 1);

    // reset during WAIT discards the command
    send_cmd(1);
    send_elem(7, 7, 7);
    tick();
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    chk("t7_err_clr", err, 0);
    chk("t7_cmd_ready", cmd_ready, 1);
    chk("t7_busy", busy, 0);
    stable = 1'b1;
    repeat (6) begin
      tick();
      if (res_valid) stable = 1'b0;
    end
    chk("t7_no_stale", stable, 1);
    send_cmd(1);
    send_elem(1, 1, 0);
    get_res("t7_r", 64'd1, 1);
    chk("t7_err", err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
